// File: rtl/nav_pkg.sv
// Shared types for the navigation unit: heading codes, command ops, FSM states
// and the heading rotation helpers.
package nav_pkg;

  typedef enum logic [2:0] {
    NORTE = 3'b001,
    OESTE = 3'b010,
    LESTE = 3'b011,
    SUL   = 3'b100
  } rumo_t;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_ESQ    = 2'b01;
  localparam logic [1:0] OP_DIR    = 2'b10;
  localparam logic [1:0] OP_AVANCA = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO,
    GIRA,
    AVANCA
  } estado_t;

  localparam logic [2:0] ACAO_PARADO = 3'b000;

  // N -> O -> S -> L -> N
  function automatic rumo_t gira_esq(input rumo_t r);
    case (r)
      NORTE:   return OESTE;
      OESTE:   return SUL;
      SUL:     return LESTE;
      default: return NORTE;
    endcase
  endfunction

  // N -> L -> S -> O -> N
  function automatic rumo_t gira_dir(input rumo_t r);
    case (r)
      NORTE:   return LESTE;
      LESTE:   return SUL;
      SUL:     return OESTE;
      default: return NORTE;
    endcase
  endfunction

endpackage

// File: rtl/nav_proximo.sv
// Next-cell calculator: one step along the heading, flagging when the step
// would leave the grid. Never wraps.
module nav_proximo
  import nav_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int XW     = 3,
  parameter int YW     = 3
) (
  input  rumo_t           rumo,
  input  logic [XW-1:0]   x,
  input  logic [YW-1:0]   y,
  output logic [XW-1:0]   nx,
  output logic [YW-1:0]   ny,
  output logic            fora
);

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  always_comb begin
    nx   = x;
    ny   = y;
    fora = 1'b0;
    case (rumo)
      NORTE:   if (y == Y_MAX) fora = 1'b1; else ny = y + 1'b1;
      SUL:     if (y == '0)    fora = 1'b1; else ny = y - 1'b1;
      LESTE:   if (x == X_MAX) fora = 1'b1; else nx = x + 1'b1;
      OESTE:   if (x == '0)    fora = 1'b1; else nx = x - 1'b1;
      default: fora = 1'b1;
    endcase
  end

endmodule

// File: rtl/robo_navegador.sv
// Command-driven navigation FSM: turns, multi-step advances with edge stop,
// registered heading/position/action outputs.
module robo_navegador
  import nav_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int STEP_W = 4,
  localparam int XW    = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  localparam int YW    = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
  input  logic              c2,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_passos,
  output logic [2:0]        orientacao,
  output logic [2:0]        acao,
  output logic [XW-1:0]     pos_x,
  output logic [YW-1:0]     pos_y,
  output logic              bloqueado,
  output logic              done
);

  estado_t           estado_q, estado_d;
  rumo_t             rumo_q, rumo_d;
  logic [XW-1:0]     x_q, x_d, nx;
  logic [YW-1:0]     y_q, y_d, ny;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              bloq_q, bloq_d;
  logic              nop_q, nop_d;
  logic              done_q, done_d;
  logic [2:0]        acao_q, acao_d;
  logic              fora;

  nav_proximo #(.GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW)) u_prox (
    .rumo (rumo_q),
    .x    (x_q),
    .y    (y_q),
    .nx   (nx),
    .ny   (ny),
    .fora (fora)
  );

  assign cmd_ready = (estado_q == OCIOSO);

  always_comb begin
    estado_d = estado_q;
    rumo_d   = rumo_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    bloq_d   = bloq_q;
    nop_d    = 1'b0;
    done_d   = nop_q;  // a nop accepted last edge completes on this one
    acao_d   = ACAO_PARADO;
    case (estado_q)
      OCIOSO: if (cmd_valid) begin
        bloq_d = 1'b0;
        case (cmd_op)
          OP_NOP:    nop_d = 1'b1;
          OP_ESQ:    begin estado_d = GIRA; dir_d = 1'b0; end
          OP_DIR:    begin estado_d = GIRA; dir_d = 1'b1; end
          OP_AVANCA: begin estado_d = AVANCA; cnt_d = cmd_passos; end
        endcase
      end
      GIRA: begin
        rumo_d   = dir_q ? gira_dir(rumo_q) : gira_esq(rumo_q);
        done_d   = 1'b1;
        estado_d = OCIOSO;
      end
      AVANCA: begin
        if (cnt_q == '0) begin
          done_d   = 1'b1;
          estado_d = OCIOSO;
        end else if (fora) begin
          // remaining steps are dropped, not resumed
          bloq_d   = 1'b1;
          done_d   = 1'b1;
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else begin
          x_d    = nx;
          y_d    = ny;
          acao_d = rumo_q;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge c2) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      rumo_q   <= NORTE;
      x_q      <= XW'(X0);
      y_q      <= YW'(Y0);
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      bloq_q   <= 1'b0;
      nop_q    <= 1'b0;
      done_q   <= 1'b0;
      acao_q   <= ACAO_PARADO;
    end else begin
      estado_q <= estado_d;
      rumo_q   <= rumo_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      bloq_q   <= bloq_d;
      nop_q    <= nop_d;
      done_q   <= done_d;
      acao_q   <= acao_d;
    end
  end

  assign orientacao = rumo_q;
  assign acao       = acao_q;
  assign pos_x      = x_q;
  assign pos_y      = y_q;
  assign bloqueado  = bloq_q;
  assign done       = done_q;

endmodule

// File: doc/robo_navegador.md
# robo_navegador

Parametrised navigation unit merging heading and advance control into one command-driven FSM. It keeps the robot's heading (N/W/E/S) and its absolute (x, y) cell on a bounded grid. It executes turn and multi-step advance commands through a valid/ready handshake, stops and flags at grid edges, and drives the per-cycle `acao` code consumed by the motor stage.

## Interface
Parameters:
- `GRID_W`, default 8: grid columns; x ranges 0..GRID_W-1.
- `GRID_H`, default 8: grid rows; y ranges 0..GRID_H-1.
- `X0`, default 0: reset x. Requirement: X0 < GRID_W.
- `Y0`, default 0: reset y. Requirement: Y0 < GRID_H.
- `STEP_W`, default 4: width of the step-count field.
- Derived: `XW = $clog2(GRID_W)`, `YW = $clog2(GRID_H)`, each minimum 1.

Ports:
- `c2`, input, 1: single clock; all logic on posedge. One clock; reset is synchronous and active-low.
- `reset`, input, 1: synchronous, active-low. Sampled only on posedge `c2`.
- `cmd_valid`, input, 1: a command is presented.
- `cmd_ready`, output, 1: the block can accept a command. High only in OCIOSO.
- `cmd_op`, input, 2: 00 = nop, 01 = girar esquerda, 10 = girar direita, 11 = avancar.
- `cmd_passos`, input, STEP_W: number of cells to advance. Ignored for other ops.
- `orientacao`, output, 3: heading. Norte = 001, Oeste = 010, Leste = 011, Sul = 100.
- `acao`, output, 3: motion code. Equals the heading code during a move cycle; 000 otherwise.
- `pos_x`, output, XW: current column.
- `pos_y`, output, YW: current row.
- `bloqueado`, output, 1: sticky. Set when the last advance was cut short by a grid edge.
- `done`, output, 1: one-cycle pulse when a command completes.

## Operation
- Coordinates: (0,0) is the south-west corner.
  - Norte: y+1. Sul: y-1. Leste: x+1. Oeste: x-1.
- Rotation:
  - esquerda: N→O→S→L→N.
  - direita: N→L→S→O→N.
- FSM states: OCIOSO, GIRA, AVANCA.
- OCIOSO:
  - A command is accepted on a posedge with `cmd_valid && cmd_ready`.
  - On acceptance, `bloqueado` clears.
  - op 01/10 → GIRA.
  - op 11 → AVANCA; load the step counter with `cmd_passos`.
  - op 00 → stay in OCIOSO; assert `done` on the next edge.
- GIRA: update `orientacao`, pulse `done`, return to OCIOSO.
- AVANCA, evaluated each edge:
  - Counter = 0: pulse `done`, set `acao` = 000, go to OCIOSO.
  - Counter ≠ 0 and next cell inside the grid: move one cell, set `acao` = heading code, decrement the counter.
  - Counter ≠ 0 and next cell outside the grid: no move, set `bloqueado` = 1, `acao` = 000, pulse `done`, go to OCIOSO. The remaining steps are discarded.
- Edge checks use full-width compares against GRID_W-1 / GRID_H-1 and 0. No wrap-around is ever allowed.
- `cmd_valid` while busy is ignored; the command is not queued.
- `cmd_passos` = 0: no move; `done` one cycle after acceptance.
- Reset values:
  - state OCIOSO.
  - `orientacao` = 001.
  - `pos_x` = X0, `pos_y` = Y0.
  - `acao` = 000, `bloqueado` = 0, `done` = 0, counter 0.
  - `cmd_ready` = 1 after the reset edge.
- Reset asserted mid-command aborts the command. All of the above apply on that edge, and no `done` is emitted.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from the state.
- Turn accepted at edge k:
  - `orientacao` new value and `done` = 1 after edge k+1.
  - `cmd_ready` high again after edge k+1.
- Advance of N unblocked steps accepted at edge k:
  - Position changes at edges k+1..k+N.
  - `acao` = heading over cycles k+1..k+N.
  - `done` and `acao` = 000 after edge k+N+1.
  - Total latency N+1 cycles.
- Blocked at step j (1-based): edge k+j gives no move, `done` = 1, `bloqueado` = 1.
- Nop: `done` after edge k+1.
- Back-to-back: earliest next acceptance is the edge on which `done` is registered.

## Structure
- Package `nav_pkg` holds:
  - heading typedef and codes (001/010/011/100).
  - `cmd_op` codes.
  - FSM state enum.
  - `ACAO_PARADO` = 000.
  - functions `gira_esq` / `gira_dir`.
- Sub-module `nav_proximo` (combinational), given heading and position:
  - outputs the next (x, y) and an `fora` flag.
  - parametrised by GRID_W/GRID_H.
- Top `robo_navegador`: FSM, counter and registers.

## Test plan
- Reset with X0 = 0, Y0 = 0; then 4× girar esquerda → orientacao sequence 010, 100, 011, 001; `done` once per command, 2 cycles apart.
- Heading Norte, avancar passos = 3 from (0,0) → pos_y 1, 2, 3 on successive edges; acao = 001 for 3 cycles; `done` on the 4th edge; bloqueado = 0.
- Heading Oeste at (0,0), avancar passos = 2 → no move; `done` and bloqueado = 1 at edge k+1; the next accepted command clears bloqueado.
- GRID_W = 4, heading Leste at x = 1, passos = 5 → x = 2, 3, then blocked at step 3; pos_x = 3, bloqueado = 1.
- Reset low during the 2nd step of a 5-step advance → next edge: pos = (X0, Y0), orientacao 001, acao 000, done 0, cmd_ready 1.
- cmd_valid pulsed while in AVANCA → ignored; position trace unchanged; passos = 0 → done at k+1, no motion.
